// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: matches the last N enabled samples of x against PATTERN,
// emits a registered one-cycle pulse per match and keeps a saturating match count.
module seq_detector_param #(
   parameter int unsigned    N       = 4,
   parameter logic [N-1:0]   PATTERN = 4'b1011,
   parameter int unsigned    CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             x,
   input  logic             overlap,
   output logic             Z,
   output logic [CNT_W-1:0] match_cnt,
   output logic             sat
);

   localparam int unsigned FW = $clog2(N + 1);
   localparam logic [FW-1:0]    FILL_MAX = FW'(N);
   localparam logic [FW-1:0]    FILL_ARM = FW'(N - 1);
   localparam logic [FW-1:0]    FILL_ONE = FW'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [N-1:0]     hist;
   logic [FW-1:0]    fill;
   logic [N-1:0]     nxt;
   logic             hit;
   logic [CNT_W-1:0] cnt_inc;

   // A window only counts once N-1 real samples precede x, so zeroed history never matches.
   always_comb begin
      nxt     = {hist[N-2:0], x};
      hit     = (fill >= FILL_ARM) && (nxt == PATTERN);
      cnt_inc = match_cnt + CNT_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist      <= '0;
         fill      <= '0;
         Z         <= 1'b0;
         match_cnt <= '0;
         sat       <= 1'b0;
      end else if (clr) begin
         hist      <= '0;
         fill      <= '0;
         Z         <= 1'b0;
         match_cnt <= '0;
         sat       <= 1'b0;
      end else if (!en) begin
         Z <= 1'b0;
      end else begin
         hist <= nxt;
         Z    <= hit;
         // Non-overlapping mode restarts the fill so no bit of the matched window is reused.
         if (hit && !overlap) begin
            fill <= '0;
         end else if (fill != FILL_MAX) begin
            fill <= fill + FILL_ONE;
         end
         if (hit && (match_cnt != CNT_MAX)) begin
            match_cnt <= cnt_inc;
         end
         if ((hit && (cnt_inc == CNT_MAX)) || (match_cnt == CNT_MAX)) begin
            sat <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: three configurations share one clock and reset,
// expectations are queued when a step is driven and checked after the sampling edge.
module tb_seq_detector_param;

   logic clk = 1'b0;
   logic rst;

   logic       en_a, clr_a, x_a, ov_a, z_a, sat_a;
   logic [7:0] cnt_a;
   logic       en_b, clr_b, x_b, ov_b, z_b, sat_b;
   logic [1:0] cnt_b;
   logic       en_c, clr_c, x_c, ov_c, z_c, sat_c;
   logic [7:0] cnt_c;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      int         dut;
      logic       z;
      logic [7:0] cnt;
      logic       sat;
      string      tag;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   seq_detector_param #(.N(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .clr(clr_a), .x(x_a), .overlap(ov_a),
      .Z(z_a), .match_cnt(cnt_a), .sat(sat_a)
   );

   seq_detector_param #(.N(2), .PATTERN(2'b11), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .clr(clr_b), .x(x_b), .overlap(ov_b),
      .Z(z_b), .match_cnt(cnt_b), .sat(sat_b)
   );

   seq_detector_param #(.N(4), .PATTERN(4'b0000), .CNT_W(8)) dut_c (
      .clk(clk), .rst(rst), .en(en_c), .clr(clr_c), .x(x_c), .overlap(ov_c),
      .Z(z_c), .match_cnt(cnt_c), .sat(sat_c)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pop_check();
      exp_t e;
      logic       z;
      logic [7:0] c;
      logic       s;
      e = sb.pop_front();
      case (e.dut)
         0:       begin z = z_a; c = cnt_a;         s = sat_a; end
         1:       begin z = z_b; c = {6'b0, cnt_b}; s = sat_b; end
         default: begin z = z_c; c = cnt_c;         s = sat_c; end
      endcase
      chk({e.tag, ".Z"},   {7'b0, z}, {7'b0, e.z});
      chk({e.tag, ".cnt"}, c,         e.cnt);
      chk({e.tag, ".sat"}, {7'b0, s}, {7'b0, e.sat});
   endtask

   task automatic step(input int dut, input logic e, input logic xv, input logic c,
                       input logic ov, input logic ez, input logic [7:0] ecnt,
                       input logic esat, input string tag);
      exp_t ex;
      @(negedge clk);
      case (dut)
         0:       begin en_a = e; x_a = xv; clr_a = c; ov_a = ov; end
         1:       begin en_b = e; x_b = xv; clr_b = c; ov_b = ov; end
         default: begin en_c = e; x_c = xv; clr_c = c; ov_c = ov; end
      endcase
      ex.dut = dut; ex.z = ez; ex.cnt = ecnt; ex.sat = esat; ex.tag = tag;
      sb.push_back(ex);
      @(posedge clk);
      #1;
      pop_check();
      case (dut)
         0:       begin en_a = 1'b0; clr_a = 1'b0; end
         1:       begin en_b = 1'b0; clr_b = 1'b0; end
         default: begin en_c = 1'b0; clr_c = 1'b0; end
      endcase
   endtask

   task automatic expect_now(input int dut, input string tag);
      exp_t ex;
      ex.dut = dut; ex.z = 1'b0; ex.cnt = 8'd0; ex.sat = 1'b0; ex.tag = tag;
      sb.push_back(ex);
      pop_check();
   endtask

   initial begin
      rst = 1'b1;
      {en_a, clr_a, x_a, ov_a} = '0;
      {en_b, clr_b, x_b, ov_b} = '0;
      {en_c, clr_c, x_c, ov_c} = '0;
      #2;
      expect_now(0, "rst_a");
      expect_now(1, "rst_b");
      expect_now(2, "rst_c");
      @(negedge clk);
      rst = 1'b0;

      // Overlapping detection of 1011 on 1011011, then 011 for a third hit
      step(0, 1, 1, 0, 1, 0, 0, 0, "ov1_b1");
      step(0, 1, 0, 0, 1, 0, 0, 0, "ov1_b2");
      step(0, 1, 1, 0, 1, 0, 0, 0, "ov1_b3");
      step(0, 1, 1, 0, 1, 1, 1, 0, "ov1_b4");
      step(0, 1, 0, 0, 1, 0, 1, 0, "ov1_b5");
      step(0, 1, 1, 0, 1, 0, 1, 0, "ov1_b6");
      step(0, 1, 1, 0, 1, 1, 2, 0, "ov1_b7");
      step(0, 1, 0, 0, 1, 0, 2, 0, "ov1_b8");
      step(0, 1, 1, 0, 1, 0, 2, 0, "ov1_b9");
      step(0, 1, 1, 0, 1, 1, 3, 0, "ov1_b10");

      // Asynchronous reset while Z=1 and count=3, checked before the next edge
      #2;
      rst = 1'b1;
      #1;
      expect_now(0, "async_rst");
      @(negedge clk);
      rst = 1'b0;

      // Non-overlapping: second 1011 reuses bits of the first window, so no hit
      step(0, 1, 1, 0, 0, 0, 0, 0, "ov0_b1");
      step(0, 1, 0, 0, 0, 0, 0, 0, "ov0_b2");
      step(0, 1, 1, 0, 0, 0, 0, 0, "ov0_b3");
      step(0, 1, 1, 0, 0, 1, 1, 0, "ov0_b4");
      step(0, 1, 0, 0, 0, 0, 1, 0, "ov0_b5");
      step(0, 1, 1, 0, 0, 0, 1, 0, "ov0_b6");
      step(0, 1, 1, 0, 0, 0, 1, 0, "ov0_b7");

      // Enable gaps with junk data while disabled
      step(0, 0, 0, 1, 1, 0, 0, 0, "gap_clr");
      for (int i = 0; i < 4; i++) begin
         logic [3:0] pat;
         pat = 4'b1011;
         step(0, 1, pat[3-i], 0, 1, (i == 3), (i == 3) ? 8'd1 : 8'd0, 0, "gap_bit");
         for (int j = 0; j < 3; j++) begin
            step(0, 0, 1'($urandom_range(1, 0)), 0, 1, 0, (i == 3) ? 8'd1 : 8'd0, 0,
                 "gap_idle");
         end
      end

      // Saturation: N=2, 11, CNT_W=2, six ones
      step(1, 1, 1, 0, 1, 0, 0, 0, "sat_b1");
      step(1, 1, 1, 0, 1, 1, 1, 0, "sat_b2");
      step(1, 1, 1, 0, 1, 1, 2, 0, "sat_b3");
      step(1, 1, 1, 0, 1, 1, 3, 1, "sat_b4");
      step(1, 1, 1, 0, 1, 1, 3, 1, "sat_b5");
      step(1, 1, 1, 0, 1, 1, 3, 1, "sat_b6");
      step(1, 0, 1, 0, 1, 0, 3, 1, "sat_hold");
      step(1, 0, 0, 1, 1, 0, 0, 0, "sat_clr");

      // Startup with all-zero pattern: only the 4th zero matches
      step(2, 1, 0, 0, 1, 0, 0, 0, "zero_b1");
      step(2, 1, 0, 0, 1, 0, 0, 0, "zero_b2");
      step(2, 1, 0, 0, 1, 0, 0, 0, "zero_b3");
      step(2, 1, 0, 0, 1, 1, 1, 0, "zero_b4");

      // clr coinciding with the would-be hit wins
      step(2, 0, 0, 1, 1, 0, 0, 0, "prio_clr0");
      step(2, 1, 0, 0, 1, 0, 0, 0, "prio_b1");
      step(2, 1, 0, 0, 1, 0, 0, 0, "prio_b2");
      step(2, 1, 0, 0, 1, 0, 0, 0, "prio_b3");
      step(2, 1, 0, 1, 1, 0, 0, 0, "prio_b4_clr");
      step(2, 1, 0, 0, 1, 0, 0, 0, "prio_after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
